image_face_bbox: RTL and testbench
==================================

IMAGE_FACE_BBOX -- requirements
Module: image_face_bbox

Interface
REQ-001 Parameter PARALLEL_NUM, default 4: pixels per beat; must match the upstream dilate stage.
REQ-002 Parameter IMG_WIDTH, default 1920: pixels per line; must be a multiple of PARALLEL_NUM.
REQ-003 Parameter IMG_HEIGHT, default 1080: lines per frame.
REQ-004 Parameter X_W, default 12: x coordinate width; must satisfy 2^X_W > IMG_WIDTH.
REQ-005 Parameter Y_W, default 11: y coordinate width; must satisfy 2^Y_W > IMG_HEIGHT.
REQ-006 Parameter ROW_MIN_PIX, default 8: minimum foreground pixels for a row to qualify; used only under the REQ-030 macro.
REQ-007 Port i_clk, input, 1: single clock; all logic runs on its rising edge.
REQ-008 Port i_rst_n, input, 1: reset; asynchronous and active-low.
REQ-009 Port i_binary, input, PARALLEL_NUM: dilated skin mask; bit 0 is the leftmost pixel of the beat.
REQ-010 Port i_valid, input, 1: beat valid; no backpressure exists.
REQ-011 Port i_user, input, 1: start of frame; qualified by i_valid.
REQ-012 Port i_last, input, 1: end of line; qualified by i_valid.
REQ-013 Port o_bbox_valid, output, 1: one-cycle pulse when the box outputs are updated.
REQ-014 Port o_found, output, 1: the frame contained at least one qualified row.
REQ-015 Ports o_x_min and o_x_max, output, X_W: inclusive horizontal extent in pixels.
REQ-016 Ports o_y_min and o_y_max, output, Y_W: inclusive vertical extent in lines.
REQ-017 Port o_err, output, 1: one-cycle pulse when a frame is aborted.

Function
REQ-018 States: IDLE, ACTIVE, MERGE, DONE; the FSM leaves IDLE only on a beat with i_valid and i_user both high.
REQ-019 x of lane j = beat_cnt*PARALLEL_NUM + j; beat_cnt clears on an accepted i_last; y increments on each accepted i_last.
REQ-020 Per row: row_min is the first set lane position, row_max the last set lane position, row_cnt the popcount sum; all are updated only on valid beats.
REQ-021 Row qualification without the macro: row_cnt is nonzero.
REQ-022 On an accepted i_last, a qualified row merges into the frame box: x_min = min, x_max = max, y_max = y; y_min is written on the first qualified row; all row accumulators then clear.
REQ-023 Frame close: i_last accepted when y = IMG_HEIGHT-1; the FSM goes ACTIVE -> MERGE -> DONE.
REQ-024 In DONE, outputs register and o_bbox_valid pulses; latency is exactly 2 cycles after the closing beat; DONE then returns to IDLE.
REQ-025 For a frame with no qualified row: o_found = 0, coordinates = 0, o_bbox_valid still pulses.
REQ-026 i_user in ACTIVE when x or y is nonzero: the partial frame is discarded, o_err pulses, o_bbox_valid does not pulse, the beat is treated as a new SOF, and the state stays ACTIVE.
REQ-027 A line overrun (beat_cnt reaches IMG_WIDTH/PARALLEL_NUM without i_last) aborts the frame like REQ-026 and sends the FSM to IDLE.
REQ-028 Box outputs hold their values between o_bbox_valid pulses.

Reset
REQ-029 While i_rst_n is low: state = IDLE; all counters and accumulators = 0; all outputs = 0, with the pulse outputs deasserted; a mid-frame reset drops that frame silently.

Configuration
REQ-030 Macro IMAGE_FACE_BBOX_ROW_THRESH_EN: when defined, a row qualifies only if row_cnt >= ROW_MIN_PIX, which rejects isolated noise rows; when undefined, REQ-021 applies and ROW_MIN_PIX is ignored.

Structure
REQ-031 Package image_face_pkg holds the bbox struct (found, x_min, x_max, y_min, y_max), the FSM state enum, and the X_W/Y_W default constants.
REQ-032 Sub-module bbox_lane_encoder is purely combinational; per beat it outputs any-set, first set lane, last set lane, and popcount.
REQ-033 The implementation targets 120-400 RTL lines; the only registers are the FSM, the counters, the row accumulators, the frame accumulators, and the output registers.

Verification (bench: IMG_WIDTH=16, IMG_HEIGHT=8, PARALLEL_NUM=4)
REQ-034 Single pixel at (x=5, y=3) -> 2 cycles after the last beat: o_bbox_valid, o_found = 1, box (5,5,3,3).
REQ-035 Rows 1-6 fully set, rows 0 and 7 empty -> box (0,15,1,6); an all-zero frame -> o_found = 0 with a pulse.
REQ-036 SOF asserted again at line 4 -> o_err pulses, no bbox pulse, then the next full frame reports correctly.
REQ-037 Reset asserted mid-frame at line 3, then a full frame -> only one bbox pulse, reflecting the new frame only.
REQ-038 With the macro and ROW_MIN_PIX=8: row 2 with 3 pixels and rows 4-5 with 10 pixels each -> y range (4,5), x taken from rows 4-5 only; without the macro, y range (2,5).

Source files
------------

// File: rtl/image_face_pkg.sv
// Shared types for the face bounding-box stage: FSM states, the box record and
// the default coordinate widths.
package image_face_pkg;

  localparam int X_W_DEF = 12;
  localparam int Y_W_DEF = 11;

  typedef enum logic [1:0] {IDLE, ACTIVE, MERGE, DONE} state_e;

  typedef struct packed {
    logic               found;
    logic [X_W_DEF-1:0] x_min;
    logic [X_W_DEF-1:0] x_max;
    logic [Y_W_DEF-1:0] y_min;
    logic [Y_W_DEF-1:0] y_max;
  } bbox_t;

endpackage

// File: rtl/bbox_lane_encoder.sv
// Combinational per-beat summary of the mask lanes: any set, first/last set
// lane (lane 0 is leftmost) and popcount.
module bbox_lane_encoder #(
  parameter int PARALLEL_NUM = 4,
  parameter int LW = (PARALLEL_NUM > 1) ? $clog2(PARALLEL_NUM) : 1,
  parameter int PW = $clog2(PARALLEL_NUM + 1)
) (
  input  logic [PARALLEL_NUM-1:0] i_bits,
  output logic                    o_any,
  output logic [LW-1:0]           o_first,
  output logic [LW-1:0]           o_last,
  output logic [PW-1:0]           o_pop
);

  always_comb begin
    o_any   = |i_bits;
    o_first = '0;
    o_last  = '0;
    o_pop   = '0;
    for (int i = PARALLEL_NUM - 1; i >= 0; i--)
      if (i_bits[i]) o_first = LW'(i);
    for (int i = 0; i < PARALLEL_NUM; i++) begin
      if (i_bits[i]) o_last = LW'(i);
      o_pop = o_pop + PW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/image_face_bbox.sv
// Accumulates the bounding box of qualified skin rows over a frame and reports
// it two cycles after the closing beat. IMAGE_FACE_BBOX_ROW_THRESH_EN enables
// the per-row minimum pixel count (ROW_MIN_PIX).
module image_face_bbox
  import image_face_pkg::*;
#(
  parameter int PARALLEL_NUM = 4,
  parameter int IMG_WIDTH    = 1920,
  parameter int IMG_HEIGHT   = 1080,
  parameter int X_W          = X_W_DEF,
  parameter int Y_W          = Y_W_DEF,
  parameter int ROW_MIN_PIX  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [PARALLEL_NUM-1:0] i_binary,
  input  logic                    i_valid,
  input  logic                    i_user,
  input  logic                    i_last,
  output logic                    o_bbox_valid,
  output logic                    o_found,
  output logic [X_W-1:0]          o_x_min,
  output logic [X_W-1:0]          o_x_max,
  output logic [Y_W-1:0]          o_y_min,
  output logic [Y_W-1:0]          o_y_max,
  output logic                    o_err
);

  localparam int BEATS = IMG_WIDTH / PARALLEL_NUM;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (PARALLEL_NUM > 1) ? $clog2(PARALLEL_NUM) : 1;
  localparam int PW    = $clog2(PARALLEL_NUM + 1);

  logic          enc_any;
  logic [LW-1:0] enc_first, enc_last;
  logic [PW-1:0] enc_pop;

  bbox_lane_encoder #(.PARALLEL_NUM(PARALLEL_NUM), .LW(LW), .PW(PW)) u_enc (
    .i_bits (i_binary),
    .o_any  (enc_any),
    .o_first(enc_first),
    .o_last (enc_last),
    .o_pop  (enc_pop)
  );

  state_e         state_q, state_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] row_min_q, row_min_d, row_max_q, row_max_d, row_cnt_q, row_cnt_d;
  bbox_t          frame_q, frame_d, out_q, out_d;
  logic           bbox_valid_q, bbox_valid_d, err_q, err_d;

  // Working copies: on a restart the beat is evaluated against a fresh frame.
  logic           process, restart, qual;
  logic [BW-1:0]  cb;
  logic [Y_W-1:0] cy;
  logic [X_W-1:0] crmin, crmax, crcnt, nrmin, nrmax, nrcnt, x_base;
  bbox_t          cf, nf;

`ifdef IMAGE_FACE_BBOX_ROW_THRESH_EN
  assign qual = (nrcnt >= X_W'(ROW_MIN_PIX));
`else
  logic [31:0] unused_row_min_pix;
  assign unused_row_min_pix = ROW_MIN_PIX;
  assign qual = (nrcnt != '0);
`endif

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    y_d          = y_q;
    row_min_d    = row_min_q;
    row_max_d    = row_max_q;
    row_cnt_d    = row_cnt_q;
    frame_d      = frame_q;
    out_d        = out_q;
    bbox_valid_d = 1'b0;
    err_d        = 1'b0;
    process      = 1'b0;
    restart      = 1'b0;

    case (state_q)
      IDLE:
        if (i_valid && i_user) begin
          process = 1'b1;
          restart = 1'b1;
          state_d = ACTIVE;
        end
      ACTIVE:
        if (i_valid) begin
          process = 1'b1;
          if (i_user && (beat_cnt_q != '0 || y_q != '0)) begin
            restart = 1'b1;
            err_d   = 1'b1;
          end
        end
      MERGE: state_d = DONE;
      DONE: begin
        out_d        = frame_q.found ? frame_q : '0;
        bbox_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cb     = restart ? '0 : beat_cnt_q;
    cy     = restart ? '0 : y_q;
    crmin  = restart ? '0 : row_min_q;
    crmax  = restart ? '0 : row_max_q;
    crcnt  = restart ? '0 : row_cnt_q;
    cf     = restart ? '0 : frame_q;
    x_base = X_W'(cb) * X_W'(PARALLEL_NUM);
    nrcnt  = crcnt + X_W'(enc_pop);
    nrmin  = (crcnt == '0 && enc_any) ? x_base + X_W'(enc_first) : crmin;
    nrmax  = enc_any ? x_base + X_W'(enc_last) : crmax;
    nf     = cf;

    if (process) begin
      if (!i_last && cb == BW'(BEATS - 1)) begin
        // Line ran past its width: drop the frame and wait for a fresh SOF.
        err_d      = 1'b1;
        state_d    = IDLE;
        beat_cnt_d = '0;
        y_d        = '0;
        row_min_d  = '0;
        row_max_d  = '0;
        row_cnt_d  = '0;
        frame_d    = '0;
      end else if (i_last) begin
        if (qual) begin
          if (!cf.found) begin
            nf.found = 1'b1;
            nf.x_min = X_W_DEF'(nrmin);
            nf.x_max = X_W_DEF'(nrmax);
            nf.y_min = Y_W_DEF'(cy);
          end else begin
            if (X_W_DEF'(nrmin) < nf.x_min) nf.x_min = X_W_DEF'(nrmin);
            if (X_W_DEF'(nrmax) > nf.x_max) nf.x_max = X_W_DEF'(nrmax);
          end
          nf.y_max = Y_W_DEF'(cy);
        end
        frame_d    = nf;
        beat_cnt_d = '0;
        row_min_d  = '0;
        row_max_d  = '0;
        row_cnt_d  = '0;
        if (cy == Y_W'(IMG_HEIGHT - 1)) begin
          y_d     = '0;
          state_d = MERGE;
        end else begin
          y_d = cy + Y_W'(1);
        end
      end else begin
        beat_cnt_d = cb + BW'(1);
        y_d        = cy;
        row_min_d  = nrmin;
        row_max_d  = nrmax;
        row_cnt_d  = nrcnt;
        frame_d    = cf;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      y_q          <= '0;
      row_min_q    <= '0;
      row_max_q    <= '0;
      row_cnt_q    <= '0;
      frame_q      <= '0;
      out_q        <= '0;
      bbox_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      y_q          <= y_d;
      row_min_q    <= row_min_d;
      row_max_q    <= row_max_d;
      row_cnt_q    <= row_cnt_d;
      frame_q      <= frame_d;
      out_q        <= out_d;
      bbox_valid_q <= bbox_valid_d;
      err_q        <= err_d;
    end
  end

  assign o_bbox_valid = bbox_valid_q;
  assign o_err        = err_q;
  assign o_found      = out_q.found;
  assign o_x_min      = X_W'(out_q.x_min);
  assign o_x_max      = X_W'(out_q.x_max);
  assign o_y_min      = Y_W'(out_q.y_min);
  assign o_y_max      = Y_W'(out_q.y_max);

endmodule

// File: tb/tb_image_face_bbox.sv
// Directed + random frames on a 16x8 image, checked against a whole-frame
// reference box computed from the pixel array.
module tb_image_face_bbox;

  localparam int PN = 4, W = 16, H = 8, XW = 12, YW = 11, RMIN = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [PN-1:0] i_binary = '0;
  logic          i_valid = 1'b0, i_user = 1'b0, i_last = 1'b0;
  logic          o_bbox_valid, o_found, o_err;
  logic [XW-1:0] o_x_min, o_x_max;
  logic [YW-1:0] o_y_min, o_y_max;

  image_face_bbox #(.PARALLEL_NUM(PN), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                    .X_W(XW), .Y_W(YW), .ROW_MIN_PIX(RMIN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_binary(i_binary), .i_valid(i_valid),
    .i_user(i_user), .i_last(i_last), .o_bbox_valid(o_bbox_valid),
    .o_found(o_found), .o_x_min(o_x_min), .o_x_max(o_x_max),
    .o_y_min(o_y_min), .o_y_max(o_y_max), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int bbox_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (o_bbox_valid) bbox_cnt <= bbox_cnt + 1;
    if (o_err)        err_cnt  <= err_cnt + 1;
  end

  logic [W-1:0] img [H];
  int e_found, e_xmin, e_xmax, e_ymin, e_ymax;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: whole-frame box over rows that meet the qualification count.
  task automatic model();
    int thr;
`ifdef IMAGE_FACE_BBOX_ROW_THRESH_EN
    thr = RMIN;
`else
    thr = 1;
`endif
    e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    for (int y = 0; y < H; y++) begin
      int lo, hi;
      if ($countones(img[y]) < thr) continue;
      lo = W; hi = -1;
      for (int x = 0; x < W; x++)
        if (img[y][x]) begin
          if (x < lo) lo = x;
          hi = x;
        end
      if (e_found == 0) begin
        e_found = 1; e_xmin = lo; e_xmax = hi; e_ymin = y;
      end else begin
        if (lo < e_xmin) e_xmin = lo;
        if (hi > e_xmax) e_xmax = hi;
      end
      e_ymax = y;
    end
  endtask

  task automatic beat(input logic [PN-1:0] b, input logic u, input logic l);
    @(negedge clk);
    i_binary = b; i_valid = 1'b1; i_user = u; i_last = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b0; i_user = 1'b0; i_last = 1'b0; i_binary = '0;
    end
  endtask

  task automatic send_lines(input int y0, input int y1, input bit sof);
    for (int y = y0; y < y1; y++)
      for (int k = 0; k < W / PN; k++)
        beat(img[y][PN*k +: PN], sof && y == y0 && k == 0, k == W / PN - 1);
  endtask

  // Call right after the closing beat has been driven.
  task automatic check_frame(input string tag);
    model();
    idle(1);
    chk({tag, ".lat1"}, o_bbox_valid, 0);
    idle(1);
    chk({tag, ".lat2"}, o_bbox_valid, 0);
    idle(1);
    chk({tag, ".valid"}, o_bbox_valid, 1);
    chk({tag, ".found"}, o_found, e_found);
    chk({tag, ".xmin"}, o_x_min, e_xmin);
    chk({tag, ".xmax"}, o_x_max, e_xmax);
    chk({tag, ".ymin"}, o_y_min, e_ymin);
    chk({tag, ".ymax"}, o_y_max, e_ymax);
    idle(1);
    chk({tag, ".pulse"}, o_bbox_valid, 0);
    chk({tag, ".hold"}, o_x_max, e_xmax);
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++) img[y] = '0;
  endtask

  task automatic rand_img();
    for (int y = 0; y < H; y++) begin
      img[y] = W'($urandom) & W'($urandom) & W'($urandom);
      if ($urandom_range(0, 3) == 0) img[y] = W'($urandom) | W'($urandom);
      if ($urandom_range(0, 4) == 0) img[y] = '0;
    end
  endtask

  initial begin
    int b0, e0, exp_ymin;
    idle(3);
    chk("rst.valid", o_bbox_valid, 0);
    chk("rst.err", o_err, 0);
    chk("rst.found", o_found, 0);
    chk("rst.xmin", o_x_min, 0);
    chk("rst.xmax", o_x_max, 0);
    chk("rst.ymin", o_y_min, 0);
    chk("rst.ymax", o_y_max, 0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    clear_img(); img[3][5] = 1'b1;
    send_lines(0, H, 1); check_frame("pix");

    clear_img(); for (int y = 1; y <= 6; y++) img[y] = '1;
    send_lines(0, H, 1); check_frame("band");

    clear_img();
    send_lines(0, H, 1); check_frame("empty");

    clear_img(); img[2] = 16'h0007; img[4] = 16'h0FFC; img[5] = 16'h3FF0;
`ifdef IMAGE_FACE_BBOX_ROW_THRESH_EN
    exp_ymin = 4;
`else
    exp_ymin = 2;
`endif
    send_lines(0, H, 1); check_frame("thresh");
    chk("thresh.ymin_const", o_y_min, exp_ymin);

    for (int r = 0; r < 6; r++) begin
      rand_img(); send_lines(0, H, 1); check_frame($sformatf("rnd%0d", r));
    end

    // SOF again at line 4: old frame aborted, new one reported.
    b0 = bbox_cnt; e0 = err_cnt;
    rand_img(); send_lines(0, 4, 1);
    rand_img(); send_lines(0, H, 1); check_frame("resof");
    chk("resof.err_pulses", err_cnt - e0, 1);
    chk("resof.bbox_pulses", bbox_cnt - b0, 1);

    // Reset in the middle of line 3, then a clean frame.
    b0 = bbox_cnt; e0 = err_cnt;
    rand_img(); img[0] = 16'h8001; send_lines(0, 3, 1);
    beat(img[3][3:0], 0, 0); beat(img[3][7:4], 0, 0);
    @(negedge clk); rst_n = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("mrst.found", o_found, 0);
    chk("mrst.xmax", o_x_max, 0);
    chk("mrst.valid", o_bbox_valid, 0);
    rst_n = 1'b1;
    idle(2);
    rand_img(); send_lines(0, H, 1); check_frame("mrst");
    chk("mrst.bbox_pulses", bbox_cnt - b0, 1);
    chk("mrst.err_pulses", err_cnt - e0, 0);

    // Line overrun: five beats of line 0 with no end-of-line marker.
    b0 = bbox_cnt; e0 = err_cnt;
    beat(4'hF, 1, 0);
    for (int k = 0; k < 4; k++) beat(4'hF, 0, 0);
    idle(5);
    chk("ovr.err_pulses", err_cnt - e0, 1);
    chk("ovr.bbox_pulses", bbox_cnt - b0, 0);
    rand_img(); send_lines(0, H, 1); check_frame("post_ovr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
